// File: rtl/filter_phase_stall_watchdog.sv
// Stall watchdog for the filter_phase core: times per-channel blocked runs, pulses
// core_rst on a timeout, waits for the core to go idle, then re-arms.
module filter_phase_stall_watchdog #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  timeout_cycles,
    input  logic [NUM_CH-1:0] block_sigs,
    input  logic              core_idle,
    input  logic              clear,
    output logic              core_rst,
    output logic              timed_out,
    output logic [NUM_CH-1:0] stall_chan,
    output logic [7:0]        event_count,
    output logic              busy
);

    localparam int unsigned FW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [FW-1:0]     flush_cnt_r;
    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic [NUM_CH-1:0] trip_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = value;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    // Per-channel trip: the current cycle completes timeout_cycles consecutive blocked cycles
    always_comb begin
        trip_s = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if ((state_r == S_ARMED) && block_sigs[i] && (timeout_cycles != '0)
                && (cnt_r[i] >= (timeout_cycles - CNT_W'(1)))) begin
                trip_s[i] = 1'b1;
            end else begin
                trip_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic; enable only gates the IDLE/ARMED decisions, never a recovery in progress
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (enable) state_next_s = S_ARMED;
                else        state_next_s = S_IDLE;
            end
            S_ARMED: begin
                if (|trip_s)      state_next_s = S_FLUSH;
                else if (!enable) state_next_s = S_IDLE;
                else              state_next_s = S_ARMED;
            end
            S_FLUSH: begin
                if (flush_cnt_r == FW'(RST_CYCLES - 1)) state_next_s = S_WAIT;
                else                                    state_next_s = S_FLUSH;
            end
            S_WAIT: begin
                if (core_idle && enable)  state_next_s = S_ARMED;
                else if (core_idle)       state_next_s = S_IDLE;
                else                      state_next_s = S_WAIT;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Per-channel consecutive-blocked counters, saturating, only live while armed
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (reset) begin
                cnt_r[i] <= '0;
            end else if ((state_r == S_ARMED) && block_sigs[i]) begin
                if (cnt_r[i] == {CNT_W{1'b1}}) cnt_r[i] <= cnt_r[i];
                else                           cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end else begin
                cnt_r[i] <= '0;
            end
        end
    end

    // State, flush timer and registered outputs; a trip outranks a coincident clear
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            flush_cnt_r <= '0;
            core_rst    <= 1'b0;
            busy        <= 1'b0;
            timed_out   <= 1'b0;
            stall_chan  <= '0;
            event_count <= 8'd0;
        end else begin
            state_r  <= state_next_s;
            core_rst <= (state_next_s == S_FLUSH);
            busy     <= (state_next_s == S_FLUSH) || (state_next_s == S_WAIT);
            if ((state_r == S_FLUSH) && (state_next_s == S_FLUSH)) begin
                flush_cnt_r <= flush_cnt_r + FW'(1);
            end else begin
                flush_cnt_r <= '0;
            end
            if (|trip_s) begin
                timed_out   <= 1'b1;
                stall_chan  <= clear ? trip_s : (stall_chan | trip_s);
                event_count <= sat_inc8(event_count);
            end else if (clear) begin
                timed_out   <= 1'b0;
                stall_chan  <= '0;
                event_count <= event_count;
            end else begin
                timed_out   <= timed_out;
                stall_chan  <= stall_chan;
                event_count <= event_count;
            end
        end
    end

endmodule

// File: tb/tb_filter_phase_stall_watchdog.sv
// Directed bench for filter_phase_stall_watchdog: per-cycle comparison against a
// run-length behavioural model, plus literal expectations for the key scenarios.
module tb_filter_phase_stall_watchdog;

    localparam int RST_CYCLES = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] timeout_cycles = 16'd0;
    logic [1:0]  block_sigs = 2'b00;
    logic        core_idle = 1'b0;
    logic        clear = 1'b0;
    logic        core_rst;
    logic        timed_out;
    logic [1:0]  stall_chan;
    logic [7:0]  event_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Model: armed flag, remaining reset-pulse cycles, waiting-for-idle flag, blocked run lengths
    bit       m_armed = 1'b0;
    bit       m_wait = 1'b0;
    int       m_left = 0;
    bit       m_to = 1'b0;
    bit [1:0] m_chan = 2'b00;
    int       m_ev = 0;
    int       m_run [2] = '{0, 0};

    filter_phase_stall_watchdog #(
        .NUM_CH(2), .CNT_W(16), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .timeout_cycles(timeout_cycles),
        .block_sigs(block_sigs), .core_idle(core_idle), .clear(clear),
        .core_rst(core_rst), .timed_out(timed_out), .stall_chan(stall_chan),
        .event_count(event_count), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance one clock: predict from the current inputs, then compare every output
    task automatic tick();
        bit       n_armed, n_wait, n_to;
        bit [1:0] n_chan, tr;
        int       n_left, n_ev;
        int       n_run [2];
        tr = 2'b00;
        if (reset) begin
            n_armed = 1'b0; n_wait = 1'b0; n_left = 0; n_to = 1'b0;
            n_chan = 2'b00; n_ev = 0; n_run = '{0, 0};
        end else begin
            n_armed = m_armed; n_wait = m_wait; n_left = m_left;
            n_to = m_to; n_chan = m_chan; n_ev = m_ev;
            if (m_armed) begin
                for (int i = 0; i < 2; i++) begin
                    if (block_sigs[i] && timeout_cycles != 16'd0 && m_run[i] + 1 >= int'(timeout_cycles))
                        tr[i] = 1'b1;
                end
            end
            if (m_left > 0) begin
                n_left = m_left - 1;
                if (n_left == 0) n_wait = 1'b1;
            end else if (m_wait) begin
                if (core_idle) begin
                    n_wait = 1'b0;
                    n_armed = enable;
                end
            end else if (m_armed) begin
                if (tr != 2'b00) begin
                    n_armed = 1'b0;
                    n_left = RST_CYCLES;
                end else if (!enable) begin
                    n_armed = 1'b0;
                end
            end else begin
                n_armed = enable;
            end
            for (int i = 0; i < 2; i++)
                n_run[i] = (m_armed && n_armed && block_sigs[i]) ? m_run[i] + 1 : 0;
            if (tr != 2'b00) begin
                n_to = 1'b1;
                n_chan = clear ? tr : (m_chan | tr);
                n_ev = (m_ev < 255) ? m_ev + 1 : 255;
            end else if (clear) begin
                n_to = 1'b0;
                n_chan = 2'b00;
            end
        end
        @(posedge clock);
        #1;
        m_armed = n_armed; m_wait = n_wait; m_left = n_left; m_to = n_to;
        m_chan = n_chan; m_ev = n_ev; m_run = n_run;
        check("core_rst", int'(core_rst), int'(m_left > 0));
        check("busy", int'(busy), int'(m_left > 0 || m_wait));
        check("timed_out", int'(timed_out), int'(m_to));
        check("stall_chan", int'(stall_chan), int'(m_chan));
        check("event_count", int'(event_count), m_ev);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int n_high;

        // Reset state
        ticks(2);
        check("rst_core_rst", int'(core_rst), 0);
        check("rst_event_count", int'(event_count), 0);
        reset = 1'b0;

        // T=4, channel 0 held blocked: trip ends the 4th armed blocked cycle
        timeout_cycles = 16'd4;
        block_sigs = 2'b01;
        enable = 1'b1;
        ticks(4);
        check("A_no_rst_yet", int'(core_rst), 0);
        tick();
        check("A_rst_rise", int'(core_rst), 1);
        check("A_stall_chan", int'(stall_chan), 1);
        check("A_event", int'(event_count), 1);
        enable = 1'b0;
        n_high = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (core_rst) n_high++;
        end
        check("A_rst_width", n_high, 8);
        check("A_busy_waiting", int'(busy), 1);
        block_sigs = 2'b00;
        core_idle = 1'b1;
        tick();
        check("A_busy_done", int'(busy), 0);
        core_idle = 1'b0;
        tick();

        // clear, then a broken blocked run never trips
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("B_clear_to", int'(timed_out), 0);
        check("B_clear_chan", int'(stall_chan), 0);
        enable = 1'b1;
        tick();
        block_sigs = 2'b01; ticks(3);
        block_sigs = 2'b00; tick();
        block_sigs = 2'b01; ticks(3);
        block_sigs = 2'b00; ticks(2);
        check("B_no_trip", int'(timed_out), 0);

        // T=5, both channels from the same cycle: one event, both bits
        reset = 1'b1; tick(); reset = 1'b0;
        timeout_cycles = 16'd5;
        block_sigs = 2'b11;
        ticks(6);
        check("C_rst", int'(core_rst), 1);
        check("C_chan", int'(stall_chan), 3);
        check("C_event", int'(event_count), 1);
        block_sigs = 2'b00;
        ticks(8);
        core_idle = 1'b1; tick(); core_idle = 1'b0;

        // clear coincident with a trip: new mask only
        timeout_cycles = 16'd2;
        block_sigs = 2'b10;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("D_chan", int'(stall_chan), 2);
        check("D_to", int'(timed_out), 1);
        check("D_event", int'(event_count), 2);
        block_sigs = 2'b00;
        core_idle = 1'b1;
        ticks(9);
        core_idle = 1'b0;

        // reset during the 3rd FLUSH cycle
        timeout_cycles = 16'd1;
        block_sigs = 2'b01;
        tick();
        block_sigs = 2'b00;
        ticks(2);
        check("E_in_flush", int'(core_rst), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("E_rst_low", int'(core_rst), 0);
        check("E_busy", int'(busy), 0);
        check("E_event", int'(event_count), 0);

        // T=0 for 70000 blocked cycles, then retime while armed with saturated counters
        timeout_cycles = 16'd0;
        block_sigs = 2'b11;
        ticks(70000);
        check("F_no_trip", int'(timed_out), 0);
        timeout_cycles = 16'd3;
        tick();
        check("F_retime_trip", int'(core_rst), 1);
        check("F_chan", int'(stall_chan), 3);
        block_sigs = 2'b00;
        core_idle = 1'b1;
        ticks(9);
        core_idle = 1'b0;

        // 260 back-to-back recoveries: event_count saturates
        reset = 1'b1; tick(); reset = 1'b0;
        timeout_cycles = 16'd1;
        block_sigs = 2'b01;
        core_idle = 1'b1;
        ticks(2601);
        check("G_event_sat", int'(event_count), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
